// File: rtl/common_pkg.sv
// Shared constants for the CPU datapath blocks.
// Every bus-facing block takes its word width from here.
package common_pkg;

   localparam int unsigned DATA_WIDTH = 8;

   typedef logic [DATA_WIDTH-1:0] data_word_t;

endpackage : common_pkg

// File: rtl/onehot_check.sv
// Flags when more than one bit of a request vector is set (popcount > 1).
// Pure combinational; shared by the conflict register and the bus assertion.
module onehot_check #(
   parameter int unsigned WIDTH = 3
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic             multi_o
);

   logic seen_one;
   logic multi;

   // Single pass: a set bit after one was already seen means two or more.
   always_comb begin
      seen_one = 1'b0;
      multi    = 1'b0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
         if (vec_i[k]) begin
            multi    = multi | seen_one;
            seen_one = 1'b1;
         end
      end
   end

   assign multi_o = multi;

endmodule : onehot_check

// File: rtl/cpu_data_mux.sv
// AND-OR data mux for the CPU data bus with output enable and a sticky
// multi-driver conflict flag.
module cpu_data_mux #(
   parameter int unsigned COUNT                = 3,
   parameter int unsigned DATA_WIDTH           = common_pkg::DATA_WIDTH,
   parameter bit          ENABLE_ONEHOT_ASSERT = 1'b1
) (
   input  logic                                clock_i,
   input  logic                                reset_i,
   input  logic [COUNT-1:0][DATA_WIDTH-1:0]    data_i,
   input  logic [COUNT-1:0]                    oe_i,
   output logic [DATA_WIDTH-1:0]               data_o,
   output logic                                oe_o,
   output logic                                conflict_o
);

   logic multi_hot;
   logic conflict_d;
   logic conflict_q;
   logic [DATA_WIDTH-1:0] mux_data;

   onehot_check #(
      .WIDTH (COUNT)
   ) u_onehot_check (
      .vec_i   (oe_i),
      .multi_o (multi_hot)
   );

   // Overlapping enables OR together rather than being prioritised.
   always_comb begin
      mux_data = '0;
      for (int unsigned k = 0; k < COUNT; k++) begin
         mux_data = mux_data | (data_i[k] & {DATA_WIDTH{oe_i[k]}});
      end
   end

   assign data_o = mux_data;
   assign oe_o   = |oe_i;

   always_comb begin
      conflict_d = conflict_q | multi_hot;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         conflict_q <= 1'b0;
      end else begin
         conflict_q <= conflict_d;
      end
   end

   assign conflict_o = conflict_q;

`ifndef SYNTHESIS
   // Deferred check so zero-time glitches on oe_i do not trip it.
   if (ENABLE_ONEHOT_ASSERT) begin : g_onehot_assert
      always_comb begin
         assert final ($isunknown(oe_i) || !multi_hot)
         else $fatal(1, "cpu_data_mux: more than one source enabled, oe_i=%b", oe_i);
      end
   end
`endif

endmodule : cpu_data_mux

// File: tb/tb_cpu_data_mux.sv
// Directed self-checking bench for cpu_data_mux (COUNT=3 and COUNT=1).
module tb_cpu_data_mux;

   logic clock_i = 1'b0;
   logic reset_i;
   logic [2:0][7:0] data_i;
   logic [2:0] oe_i;
   logic [7:0] data_o;
   logic oe_o;
   logic conflict_o;

   logic [0:0][7:0] c1_data_i;
   logic [0:0] c1_oe_i;
   logic [7:0] c1_data_o;
   logic c1_oe_o;
   logic c1_conflict_o;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clock_i = ~clock_i;

   cpu_data_mux #(
      .COUNT                (3),
      .DATA_WIDTH           (8),
      .ENABLE_ONEHOT_ASSERT (1'b0)
   ) u_dut (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .data_i     (data_i),
      .oe_i       (oe_i),
      .data_o     (data_o),
      .oe_o       (oe_o),
      .conflict_o (conflict_o)
   );

   cpu_data_mux #(
      .COUNT      (1),
      .DATA_WIDTH (8)
   ) u_dut_c1 (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .data_i     (c1_data_i),
      .oe_i       (c1_oe_i),
      .data_o     (c1_data_o),
      .oe_o       (c1_oe_o),
      .conflict_o (c1_conflict_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_i   = 1'b1;
      data_i[0] = 8'hAA;
      data_i[1] = 8'hBB;
      data_i[2] = 8'hCC;
      oe_i      = 3'b000;
      c1_data_i = '0;
      c1_oe_i   = 1'b0;
      repeat (2) @(posedge clock_i);
      #1;
      check("reset_conflict", {31'd0, conflict_o}, 32'd0);
      check("idle_oe", {31'd0, oe_o}, 32'd0);
      check("idle_data", {24'd0, data_o}, 32'h00);

      // Combinational outputs stay live while reset is held.
      oe_i = 3'b010;
      #1;
      check("data_in_reset", {24'd0, data_o}, 32'hBB);
      check("oe_in_reset", {31'd0, oe_o}, 32'd1);

      @(negedge clock_i);
      reset_i = 1'b0;
      oe_i = 3'b001;
      #1;
      check("sel0_data", {24'd0, data_o}, 32'hAA);
      check("sel0_oe", {31'd0, oe_o}, 32'd1);
      oe_i = 3'b010;
      #1;
      check("sel1_data", {24'd0, data_o}, 32'hBB);
      oe_i = 3'b100;
      #1;
      check("sel2_data", {24'd0, data_o}, 32'hCC);
      data_i[2] = 8'hDD;
      #1;
      check("sel2_follow", {24'd0, data_o}, 32'hDD);
      oe_i = 3'b001;
      #1;
      check("back_to_sel0", {24'd0, data_o}, 32'hAA);
      oe_i = 3'b000;
      #1;
      check("none_oe", {31'd0, oe_o}, 32'd0);
      check("none_data", {24'd0, data_o}, 32'h00);
      @(negedge clock_i);
      check("no_conflict_onehot", {31'd0, conflict_o}, 32'd0);

      // One-cycle reset pulse, then a two-source conflict.
      reset_i = 1'b1;
      @(negedge clock_i);
      reset_i = 1'b0;
      oe_i = 3'b011;
      #1;
      check("multi_data", {24'd0, data_o}, 32'hBB);
      check("multi_oe", {31'd0, oe_o}, 32'd1);
      check("conflict_not_yet", {31'd0, conflict_o}, 32'd0);
      @(posedge clock_i);
      #1;
      check("conflict_set", {31'd0, conflict_o}, 32'd1);

      @(negedge clock_i);
      oe_i = 3'b001;
      @(negedge clock_i);
      @(negedge clock_i);
      check("conflict_sticky", {31'd0, conflict_o}, 32'd1);

      reset_i = 1'b1;
      @(negedge clock_i);
      reset_i = 1'b0;
      #1;
      check("conflict_cleared", {31'd0, conflict_o}, 32'd0);

      // Reset wins over a conflict sampled on the same edge.
      @(negedge clock_i);
      reset_i = 1'b1;
      oe_i = 3'b110;
      #1;
      check("multi_or_data", {24'd0, data_o}, 32'hFF);
      @(negedge clock_i);
      check("reset_priority", {31'd0, conflict_o}, 32'd0);
      reset_i = 1'b0;
      oe_i = 3'b000;

      // Different bit patterns expose OR versus priority behaviour.
      data_i[0] = 8'h0F;
      data_i[2] = 8'hF0;
      oe_i = 3'b101;
      #1;
      check("or_0_2", {24'd0, data_o}, 32'hFF);
      data_i[0] = 8'h81;
      data_i[1] = 8'h42;
      data_i[2] = 8'h24;
      oe_i = 3'b111;
      #1;
      check("or_all", {24'd0, data_o}, 32'hE7);
      @(negedge clock_i);
      check("conflict_from_or", {31'd0, conflict_o}, 32'd1);
      oe_i = 3'b000;

      // Single-source configuration.
      c1_data_i[0] = 8'h5A;
      c1_oe_i = 1'b1;
      #1;
      check("c1_data", {24'd0, c1_data_o}, 32'h5A);
      check("c1_oe", {31'd0, c1_oe_o}, 32'd1);
      repeat (3) @(negedge clock_i);
      check("c1_no_conflict", {31'd0, c1_conflict_o}, 32'd0);
      c1_oe_i = 1'b0;
      #1;
      check("c1_idle_data", {24'd0, c1_data_o}, 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule : tb_cpu_data_mux

// File: doc/cpu_data_mux.md
CPU_DATA_MUX -- requirements
Module: cpu_data_mux

Interface
REQ-001 Parameter COUNT, default 3: number of CPU data bus sources; SHALL be legal for any value >= 1.
REQ-002 Parameter DATA_WIDTH, default common_pkg::DATA_WIDTH (8): width of each data word.
REQ-003 Port clock_i  input  1: system clock; the only clock.
REQ-004 Port reset_i  input  1: synchronous, active-high reset, sampled on the rising edge of clock_i.
REQ-005 Port data_i  input  [COUNT-1:0][DATA_WIDTH-1:0]: candidate data word of each source; index k is source k.
REQ-006 Port oe_i  input  [COUNT-1:0]: output enable of each source; bit k set means source k drives the CPU bus.
REQ-007 Port data_o  output  DATA_WIDTH: selected data word to the CPU data bus.
REQ-008 Port oe_o  output  1: CPU data bus output enable, high when any source is enabled.
REQ-009 Port conflict_o  output  1: sticky, registered flag, high once more than one oe_i bit has been seen high on a clock edge.

Function
REQ-010 oe_o SHALL be combinational: the OR of all oe_i bits, with no clock latency.
REQ-011 data_o SHALL be combinational, with zero latency from data_i and oe_i, and no register in the path.
REQ-012 When exactly one bit oe_i[k] is set, data_o SHALL equal data_i[k], and SHALL follow data_i[k] changes in the same delta.
REQ-013 When no oe_i bit is set, data_o SHALL be all zeros and oe_o SHALL be 0.
REQ-014 data_o SHALL be the AND-OR of all sources: the bitwise OR over k of (data_i[k] masked by oe_i[k]); a priority encoder SHALL NOT be used.
REQ-015 When multiple oe_i bits are set, data_o SHALL be the bitwise OR of the enabled sources, per REQ-014.
REQ-016 When multiple oe_i bits are set, oe_o SHALL be 1.
REQ-017 At each rising clock_i edge with reset_i low, conflict_o SHALL be set if two or more oe_i bits are high.
REQ-018 conflict_o SHALL stay set until reset and SHALL be visible one cycle after the offending edge.
REQ-019 A simulation-only immediate assertion SHALL call $fatal when more than one oe_i bit is high.
REQ-020 The REQ-019 assertion SHALL be excluded from synthesis.
REQ-021 The REQ-019 assertion SHALL be evaluated only after inputs settle, in a deferred or final check, so that zero-time glitches do not fire it.
REQ-022 Inputs containing X or Z SHALL NOT fire the REQ-019 assertion.

Reset
REQ-023 While reset_i is high at a rising clock_i edge, conflict_o SHALL clear to 0.
REQ-024 A conflict present during the same edge as reset_i SHALL NOT set conflict_o; reset has priority.
REQ-025 reset_i SHALL have no effect on the combinational outputs data_o and oe_o, which are valid even during reset.

Structure
REQ-026 DATA_WIDTH SHALL come from the shared common_pkg.
REQ-027 The module SHALL NOT declare a local data width.
REQ-028 The one-hot check (popcount > 1 of oe_i) SHALL be a small combinational sub-module, onehot_check, reused by both the conflict register and the assertion.
REQ-029 The mux body SHALL be a generate or for-loop over COUNT.
REQ-030 The module SHALL contain no latches and no tri-states.

Verification
REQ-031 Data AA/BB/CC, oe_i=000 -> oe_o=0, data_o=00.
REQ-032 oe_i=001, then 010, then 100 -> oe_o=1, data_o=AA, then BB, then CC, each within 1 time unit without a clock edge.
REQ-033 oe_i=100, data_i[2] changed to DD -> data_o=DD; then oe_i=001 -> data_o=AA; then oe_i=000 -> oe_o=0.
REQ-034 Reset pulsed for one cycle, then oe_i=011 held across one clock edge with the assertion disabled -> data_o=BB|AA=BB, oe_o=1, conflict_o=1 on the next cycle.
REQ-035 After REQ-034, oe_i returned to 001 -> conflict_o stays 1.
REQ-036 After REQ-035, reset_i high for one edge -> conflict_o=0.
REQ-037 reset_i high together with oe_i=110 at the same edge -> conflict_o remains 0.
REQ-038 With COUNT=1, oe_i=1 and data_i=5A -> data_o=5A and conflict_o never sets.
